rdma_tx_queue: RTL and testbench
================================

# rdma_tx_queue

Buffered, parametrised successor to the RDMA TX pass-through stage. Accepts packet beats on a valid/ready input, stores them in a DEPTH-entry FIFO, and presents them on a valid/ready output with full backpressure. Enforces a maximum packet length by truncating oversize packets. Emits a one-cycle completion pulse carrying beat count and error status per delivered packet. Sits between the RC send engine and the link-layer framer.

## Interface
- DATA_W, 64, beat payload width
- DEPTH, 8, FIFO entries; power of 2, ≥ 2
- MAX_BEATS, 256, maximum beats per packet; ≥ 2
- BEAT_W, $clog2(MAX_BEATS+1), width of beat counters (derived, not overridden)
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- tx_in_valid  in  1  input beat valid
- tx_in_ready  out  1  input beat accepted when valid && ready
- tx_in_data  in  DATA_W  input beat payload
- tx_in_last  in  1  final beat of packet
- tx_valid  out  1  output beat valid
- tx_ready  in  1  downstream accepts beat
- tx_data  out  DATA_W  output payload; 0 when !tx_valid
- tx_last  out  1  output final beat; 0 when !tx_valid
- tx_done  out  1  one-cycle pulse per packet fully delivered
- tx_done_beats  out  BEAT_W  beats in that packet; valid with tx_done
- tx_err  out  1  packet was truncated; valid with tx_done
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- pkt_cnt  out  32  delivered-packet counter (only with RDMA_TX_PKT_CNT_EN)

## Operation
- FIFO entry = {err, last, data}. Write pointer, read pointer, and level counter are registered. Pointers wrap modulo DEPTH.
- Input FSM has three states:
  - IDLE: no packet open. An accepted beat with last=0 goes to ACTIVE with in_cnt=1. An accepted beat with last=1 writes a 1-beat packet and stays in IDLE.
  - ACTIVE: in_cnt increments per accepted beat. A beat with last=1 returns to IDLE.
  - Truncation: when the accepted beat is the MAX_BEATS-th and last=0, it is written with last=1, err=1, and the FSM moves to DROP.
  - DROP: tx_in_ready=1 regardless of FIFO state. Beats are discarded, nothing is written. An accepted beat with last=1 returns to IDLE.
- tx_in_ready = (level < DEPTH) in IDLE/ACTIVE; 1 in DROP.
- Output side presents the FIFO head: tx_valid = (level != 0). Pop on tx_valid && tx_ready.
- Output beat counter out_cnt increments per pop. On pop of a beat with last=1:
  - next cycle: tx_done=1, tx_done_beats=out_cnt+1, tx_err=entry err bit;
  - out_cnt clears to 0.
- Arithmetic: counters are unsigned and never exceed MAX_BEATS; no wrap possible. pkt_cnt wraps 2^32−1 → 0.

## Timing
- Reset values: every output 0, except tx_in_ready=1 (level=0, IDLE). FSM=IDLE, pointers, counters and level all 0. FIFO memory is not reset.
- Latency: a beat accepted at edge N gives tx_valid=1 in the cycle after edge N (1 cycle, no fall-through).
- Output hold: while tx_valid && !tx_ready, tx_data/tx_last stay stable.
- Simultaneous push and pop: level unchanged.
  - At full: no push, because ready was 0 that cycle, even though a pop occurs.
  - At empty: no pop, because tx_valid=0.
- tx_done: asserted exactly one cycle, the cycle after the last-beat pop. Back-to-back single-beat packets give tx_done high on consecutive cycles.
- Reset mid-packet: the partial packet is discarded, no tx_done is produced, and the FSM returns to IDLE.

## Configuration
- RDMA_TX_PKT_CNT_EN defined:
  - pkt_cnt port exists;
  - it increments in the same cycle tx_done asserts, including truncated packets;
  - reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package rdma_tx_pkg holds:
  - the input FSM state enum (IDLE, ACTIVE, DROP);
  - the FIFO entry struct {err, last, data} parametrised by DATA_W;
  - default constants for DATA_W, DEPTH, MAX_BEATS.
- One sub-module, rdma_tx_fifo: a synchronous DEPTH×(DATA_W+2) FIFO with level output. Packet logic and completion logic stay in the top.

## Test plan
- Reset then one 3-beat packet, data 0x11/0x22/0x33, tx_ready=1 → tx_valid from cycle 1; tx_done one cycle after the third pop; tx_done_beats=3, tx_err=0.
- DEPTH=8, tx_ready=0, drive 10 beats → tx_in_ready drops after the 8th; fifo_level=8; release tx_ready → all 8 delivered in order, and the remaining 2 are then accepted.
- MAX_BEATS=4, 7-beat packet → 4 beats output, 4th with tx_last=1; beats 5–7 accepted and dropped; tx_done_beats=4, tx_err=1.
- Full FIFO with tx_ready=1 and tx_in_valid=1 simultaneously → level stays 8 for one cycle then 7; no beat is lost or duplicated.
- Five single-beat packets back-to-back → tx_done high five consecutive cycles, each tx_done_beats=1; with RDMA_TX_PKT_CNT_EN, pkt_cnt=5.
- Assert rst mid-packet after 2 beats → all outputs 0 immediately; next packet is reported with the correct beat count.

Source files
------------

// File: rtl/rdma_tx_pkg.sv
// Shared types and default constants for the RDMA TX queue.
package rdma_tx_pkg;

  localparam int RDMA_TX_DATA_W    = 64;
  localparam int RDMA_TX_DEPTH     = 8;
  localparam int RDMA_TX_MAX_BEATS = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } in_state_e;

  // Entry at the default payload width; the top re-declares it at its own DATA_W.
  typedef struct packed {
    logic                      err;
    logic                      last;
    logic [RDMA_TX_DATA_W-1:0] data;
  } tx_entry_t;

endpackage

// File: rtl/rdma_tx_queue_fifo.sv
// Synchronous DEPTH x W FIFO with occupancy output; memory is not reset.
module rdma_tx_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (!do_push && do_pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rdma_tx_queue.sv
// Buffered RDMA TX stage: packet FIFO, max-length truncation, per-packet completion.
// Optional delivered-packet counter enabled by RDMA_TX_PKT_CNT_EN.
module rdma_tx_queue
  import rdma_tx_pkg::*;
#(
  parameter int DATA_W    = RDMA_TX_DATA_W,
  parameter int DEPTH     = RDMA_TX_DEPTH,
  parameter int MAX_BEATS = RDMA_TX_MAX_BEATS,
  localparam int BEAT_W   = $clog2(MAX_BEATS + 1),
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_in_valid,
  output logic              tx_in_ready,
  input  logic [DATA_W-1:0] tx_in_data,
  input  logic              tx_in_last,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_last,
  output logic              tx_done,
  output logic [BEAT_W-1:0] tx_done_beats,
  output logic              tx_err,
  output logic [LVL_W-1:0]  fifo_level
`ifdef RDMA_TX_PKT_CNT_EN
  ,
  output logic [31:0]       pkt_cnt
`endif
);

  // Handshake: a beat moves on a rising edge where valid && ready; valid never waits on ready.
  typedef struct packed {
    logic              err;
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  in_state_e         state_q, state_d;
  logic [BEAT_W-1:0] in_cnt_q, in_cnt_d;
  logic [BEAT_W-1:0] out_cnt_q, out_cnt_d;
  logic              done_q, done_d;
  logic [BEAT_W-1:0] done_beats_q, done_beats_d;
  logic              err_q, err_d;
  logic              accept, wr_en, pop, fifo_full, fifo_empty;
  entry_t            wr_entry, head;

  rdma_tx_fifo #(.W(DATA_W + 2), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_en),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // DROP swallows the tail of a truncated packet even when the FIFO is full.
  assign tx_in_ready = (state_q == ST_DROP) || !fifo_full;
  assign accept      = tx_in_valid && tx_in_ready;

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    wr_en    = 1'b0;
    wr_entry = '{err: 1'b0, last: tx_in_last, data: tx_in_data};
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_en = 1'b1;
          if (!tx_in_last) begin
            state_d  = ST_ACTIVE;
            in_cnt_d = BEAT_W'(1);
          end
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          wr_en = 1'b1;
          if (tx_in_last) begin
            state_d  = ST_IDLE;
            in_cnt_d = '0;
          end else if (in_cnt_q == BEAT_W'(MAX_BEATS - 1)) begin
            wr_entry.last = 1'b1;
            wr_entry.err  = 1'b1;
            state_d       = ST_DROP;
            in_cnt_d      = '0;
          end else begin
            in_cnt_d = in_cnt_q + BEAT_W'(1);
          end
        end
      end
      ST_DROP: begin
        if (accept && tx_in_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_valid = !fifo_empty;
  assign tx_data  = tx_valid ? head.data : '0;
  assign tx_last  = tx_valid ? head.last : 1'b0;
  assign pop      = tx_valid && tx_ready;

  always_comb begin
    out_cnt_d    = out_cnt_q;
    done_d       = 1'b0;
    done_beats_d = '0;
    err_d        = 1'b0;
    if (pop) begin
      if (head.last) begin
        out_cnt_d    = '0;
        done_d       = 1'b1;
        done_beats_d = out_cnt_q + BEAT_W'(1);
        err_d        = head.err;
      end else begin
        out_cnt_d = out_cnt_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      done_q       <= 1'b0;
      done_beats_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      done_q       <= done_d;
      done_beats_q <= done_beats_d;
      err_q        <= err_d;
    end
  end

  assign tx_done       = done_q;
  assign tx_done_beats = done_beats_q;
  assign tx_err        = err_q;

`ifdef RDMA_TX_PKT_CNT_EN
  logic [31:0] pkt_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pkt_cnt_q <= '0;
    else if (done_d) pkt_cnt_q <= pkt_cnt_q + 32'd1;
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_rdma_tx_queue.sv
// Self-checking bench for rdma_tx_queue (DEPTH=8, MAX_BEATS=4 to reach truncation quickly).
module tb_rdma_tx_queue;

  localparam int DATA_W    = 64;
  localparam int DEPTH     = 8;
  localparam int MAX_BEATS = 4;
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int LVL_W     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              tx_in_valid;
  logic              tx_in_ready;
  logic [DATA_W-1:0] tx_in_data;
  logic              tx_in_last;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic              tx_done;
  logic [BEAT_W-1:0] tx_done_beats;
  logic              tx_err;
  logic [LVL_W-1:0]  fifo_level;
`ifdef RDMA_TX_PKT_CNT_EN
  logic [31:0]       pkt_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  // Scoreboard: beats as {last, data}, completions as {err, beats}.
  logic [DATA_W:0] exp_q[$];
  logic [BEAT_W:0] done_q[$];
  int   m_cnt  = 0;
  logic m_drop = 1'b0;

  rdma_tx_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_in_valid   (tx_in_valid),
    .tx_in_ready   (tx_in_ready),
    .tx_in_data    (tx_in_data),
    .tx_in_last    (tx_in_last),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_last       (tx_last),
    .tx_done       (tx_done),
    .tx_done_beats (tx_done_beats),
    .tx_err        (tx_err),
    .fifo_level    (fifo_level)
`ifdef RDMA_TX_PKT_CNT_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model of the input side: truncation at MAX_BEATS, drop until last.
  task automatic model_accept(input logic [DATA_W-1:0] d, input logic l);
    if (m_drop) begin
      if (l) m_drop = 1'b0;
    end else begin
      m_cnt++;
      if (l) begin
        exp_q.push_back({1'b1, d});
        done_q.push_back({1'b0, BEAT_W'(m_cnt)});
        m_cnt = 0;
      end else if (m_cnt == MAX_BEATS) begin
        exp_q.push_back({1'b1, d});
        done_q.push_back({1'b1, BEAT_W'(MAX_BEATS)});
        m_drop = 1'b1;
        m_cnt  = 0;
      end else begin
        exp_q.push_back({1'b0, d});
      end
    end
  endtask

  // Driver: called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic l);
    int   waited = 0;
    logic acc    = 1'b0;
    tx_in_valid = 1'b1;
    tx_in_data  = d;
    tx_in_last  = l;
    while (!acc) begin
      @(negedge clk);
      acc = tx_in_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
          break;
        end
      end
    end
    if (acc) model_accept(d, l);
    tx_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (cyc >= 100) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats and %0d completions outstanding, required 0",
               name, exp_q.size(), done_q.size());
    end
  endtask

  // Monitor: compares output beats and completions against the scoreboard.
  initial begin
    logic [DATA_W:0] eb;
    logic [BEAT_W:0] ed;
    logic            prev_last_pop;
    prev_last_pop = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_last_pop = 1'b0;
      end else begin
        n_checks++;
        if (tx_done !== prev_last_pop) begin
          n_fail++;
          $display("FAIL done_timing: tx_done=%b, required %b", tx_done, prev_last_pop);
        end
        if (tx_done === 1'b1) begin
          done_seen++;
          n_checks++;
          if (done_q.size() == 0) begin
            n_fail++;
            $display("FAIL done_unexpected: tx_done with no packet outstanding");
          end else begin
            ed = done_q.pop_front();
            if ({tx_err, tx_done_beats} !== ed) begin
              n_fail++;
              $display("FAIL done_info: err=%b beats=%0d, required err=%b beats=%0d",
                       tx_err, tx_done_beats, ed[BEAT_W], ed[BEAT_W-1:0]);
            end
          end
        end
        if (tx_valid !== 1'b1) begin
          n_checks++;
          if (tx_data !== '0 || tx_last !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_output: data=%0h last=%b, required 0/0", tx_data, tx_last);
          end
        end
        prev_last_pop = tx_valid && tx_ready && tx_last;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: data=%0h last=%b", tx_data, tx_last);
          end else begin
            eb = exp_q.pop_front();
            if ({tx_last, tx_data} !== eb) begin
              n_fail++;
              $display("FAIL beat: data=%0h last=%b, required data=%0h last=%b",
                       tx_data, tx_last, eb[DATA_W-1:0], eb[DATA_W]);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    tx_ready = 1'b0;
    tx_in_valid = 1'b0;
    tx_in_data = '0;
    tx_in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (tx_in_ready !== 1'b1 || tx_valid !== 1'b0 || tx_done !== 1'b0 ||
        fifo_level !== '0 || tx_data !== '0 || tx_err !== 1'b0 || tx_done_beats !== '0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b valid=%b done=%b level=%0d data=%0h, required 1/0/0/0/0",
               tx_in_ready, tx_valid, tx_done, fifo_level, tx_data);
    end
`ifdef RDMA_TX_PKT_CNT_EN
    n_checks++;
    if (pkt_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_pkt_cnt: %0d, required 0", pkt_cnt);
    end
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    tx_ready = 1'b1;
    send_beat(64'h11, 1'b0);
    n_checks++;
    if (tx_valid !== 1'b1 || fifo_level !== LVL_W'(1)) begin
      n_fail++;
      $display("FAIL basic_latency: valid=%b level=%0d, required 1/1", tx_valid, fifo_level);
    end
    send_beat(64'h22, 1'b0);
    send_beat(64'h33, 1'b1);
    wait_drain("basic");
  endtask

  task automatic test_backpressure();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(64'hA0 + 64'(i), (i % 2) == 1);
    n_checks++;
    if (fifo_level !== LVL_W'(8) || tx_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: level=%0d in_ready=%b, required 8/0", fifo_level, tx_in_ready);
    end
    tx_in_valid = 1'b1;
    tx_in_data  = 64'hA8;
    tx_in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (fifo_level !== LVL_W'(8)) begin
      n_fail++;
      $display("FAIL bp_hold: level=%0d, required 8", fifo_level);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fifo_level !== LVL_W'(8) || tx_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_simul_first: level=%0d in_ready=%b, required 8/0", fifo_level, tx_in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (fifo_level !== LVL_W'(7)) begin
      n_fail++;
      $display("FAIL full_simul_pop: level=%0d, required 7", fifo_level);
    end
    send_beat(64'hA8, 1'b0);
    n_checks++;
    if (fifo_level !== LVL_W'(7)) begin
      n_fail++;
      $display("FAIL push_pop_level: level=%0d, required 7", fifo_level);
    end
    send_beat(64'hA9, 1'b1);
    wait_drain("backpressure");
  endtask

  task automatic test_truncate();
    tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_beat(64'h100 + 64'(i), i == 6);
    wait_drain("truncate");
    // Packet after a truncation must start counting afresh.
    send_beat(64'h200, 1'b0);
    send_beat(64'h201, 1'b1);
    wait_drain("after_truncate");
  endtask

  task automatic test_back_to_back();
    int before_done = done_seen;
`ifdef RDMA_TX_PKT_CNT_EN
    logic [31:0] before_cnt = pkt_cnt;
`endif
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(64'(32'hB0 + $urandom_range(0, 15)), 1'b1);
    wait_drain("back_to_back");
    n_checks++;
    if (done_seen - before_done != 5) begin
      n_fail++;
      $display("FAIL b2b_done_count: %0d, required 5", done_seen - before_done);
    end
`ifdef RDMA_TX_PKT_CNT_EN
    n_checks++;
    if (pkt_cnt - before_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL b2b_pkt_cnt: delta %0d, required 5", pkt_cnt - before_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b1;
    send_beat(64'hC0, 1'b0);
    send_beat(64'hC1, 1'b0);
    n_checks++;
    if (tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_valid: valid=%b, required 1", tx_valid);
    end
    rst = 1'b1;
    #1;
    exp_q.delete();
    done_q.delete();
    m_cnt  = 0;
    m_drop = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== '0 || tx_last !== 1'b0 || tx_done !== 1'b0 ||
        fifo_level !== '0 || tx_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: valid=%b data=%0h last=%b done=%b level=%0d in_ready=%b",
               tx_valid, tx_data, tx_last, tx_done, fifo_level, tx_in_ready);
    end
`ifdef RDMA_TX_PKT_CNT_EN
    n_checks++;
    if (pkt_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_pkt_cnt: %0d, required 0", pkt_cnt);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_beat(64'hD0, 1'b0);
    send_beat(64'hD1, 1'b0);
    send_beat(64'hD2, 1'b1);
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_truncate();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
